alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequential front end for the combinational 16-bit ALU: accepts an ALU command (valid/ready), registers the
//  operands, drives the ALU's A/B/Cin/op_type/func/shift_count_ni ports, and captures S and CVZN.
//  Runs 32-bit ("wide") ALU_3 ops as two chained 16-bit passes, low half first, carry fed into the high pass.
//  Returns a 32-bit result plus CVZN on a valid/ready response channel; sits between the decode and writeback stages.
// PARAMETERS
//  (none) -- datapath fixed at 16-bit ALU / 32-bit wide result; opcode encodings match the ALU (op_type 001/010/100).
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   command accepted when cmd_valid & cmd_ready
//  cmd_op         in   3   ALU op_type (001 ALU_3, 010 ALU_2, 100 shift, else -> result 0)
//  cmd_func       in   3   ALU func
//  cmd_shift      in   3   shift count minus one (ALU shift_count_ni)
//  cmd_wide       in   1   32-bit op; honoured only when cmd_op==001
//  cmd_a, cmd_b   in   32  operands; only [15:0] used for narrow ops
//  cmd_cin        in   1   carry-in for ADC/SBC/RCL/RCR
//  cmd_use_flag   in   1   take Cin from the stored C flag (FLAG_REG_EN only)
//  alu_a, alu_b   out  16  to ALU A/B
//  alu_cin        out  1   to ALU Cin
//  alu_op_type    out  3   to ALU op_type
//  alu_func       out  3   to ALU func
//  alu_shift      out  3   to ALU shift_count_ni
//  alu_s          in   16  from ALU S (combinational, same cycle)
//  alu_cvzn       in   4   from ALU CVZN {C,V,Z,N}
//  rsp_valid      out  1   result available
//  rsp_ready      in   1   result consumed when rsp_valid & rsp_ready
//  rsp_s          out  32  result; [31:16]=0 for narrow ops
//  rsp_cvzn       out  4   flags {C,V,Z,N}
//  flags_q        out  4   persistent flag register (0 when FLAG_REG_EN undefined)
// BEHAVIOUR
//  - Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_s=0, rsp_cvzn=0, flags_q=0, all alu_* outputs=0. Reset wins over every other event.
//  - FSM: IDLE -> (accept) LO -> (wide) HI -> RESP, or LO -> RESP for narrow; RESP -> IDLE on rsp_ready.
//  - cmd_ready=1 only in IDLE; command and operands registered on acceptance; no new accept until RESP retires.
//  - alu_* are registered and driven from command registers; they drive 0 outside LO/HI.
//  - LO: alu_a/b = a[15:0]/b[15:0]; capture alu_s -> s_lo, alu_cvzn -> f_lo.
//  - HI: alu_a/b = a[31:16]/b[31:16], alu_cin = f_lo.C; func remap: ADD(4)->ADC(5), SUB(6)->SBC(7); other funcs unchanged.
//  - Low-pass Cin: cmd_cin (or flags_q.C per FLAG_REG_EN); for wide ADC/SBC the low pass keeps func 5/7 with that Cin.
//  - Wide flags: C,V,N from the high pass; Z = (s_lo==0)&(s_hi==0). Narrow flags = f_lo unchanged.
//  - Latency: accept at edge k -> LO in cycle k+1 -> rsp_valid at k+2 (narrow) or k+3 (wide).
//  - RESP: rsp_valid=1; rsp_s/rsp_cvzn held stable until rsp_ready; same-cycle ready retires, IDLE next cycle.
//  - Wide with cmd_op!=001: executed narrow, rsp_s[31:16]=0. Undefined op_type: result 0, flags C=V=N=0, Z=1.
//  - Reset in LO/HI/RESP: in-flight command discarded, no response emitted.
// CONFIGURATION
//  - FLAG_REG_EN defined: flags_q <= rsp_cvzn on each response handshake; when cmd_use_flag=1 the low-pass Cin = flags_q.C and cmd_cin is ignored.
//  - FLAG_REG_EN undefined: no flag register; flags_q tied 0; cmd_use_flag ignored; Cin always cmd_cin.
// TESTING
//  - Narrow ADD 0x7FFF+0x0001 -> rsp_s=0x0000_8000, cvzn=0101, rsp_valid 2 cycles after accept.
//  - Wide ADD 0x0000_FFFF+0x0000_0001 -> 0x0001_0000, cvzn=0000; HI pass shows alu_func=5, alu_cin=1.
//  - Wide ADD 0xFFFF_FFFF+0x0000_0001 -> 0x0000_0000, cvzn=1010 (C=1,Z=1).
//  - Wide SUB 0x0001_0000-0x0000_0001 -> 0x0000_FFFF, C=1 (no borrow), Z=0, N=0; HI alu_func=7, alu_cin=0.
//  - SHL op=100 func=0 shift=0, A=0x8001 -> 0x0002, C=1; hold rsp_ready=0 for 3 cycles -> rsp stable, cmd_ready=0.
//  - rst asserted during HI -> next cycle rsp_valid=0, cmd_ready=1, alu_* = 0; FLAG_REG_EN: ADC with cmd_use_flag after a C=1 result adds 1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered front end for the combinational 16-bit ALU.
// Takes one command at a time, runs narrow ops in one ALU pass, and runs
// wide (32-bit) ALU_3 ops in two chained passes, low half first.
// Optional feature macro: FLAG_REG_EN keeps a persistent CVZN register and
// lets cmd_use_flag_i take the low-pass carry-in from its C bit.
module alu_op_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [2:0]  cmd_func_i,
  input  logic [2:0]  cmd_shift_i,
  input  logic        cmd_wide_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic        cmd_cin_i,
  input  logic        cmd_use_flag_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic        alu_cin_o,
  output logic [2:0]  alu_op_type_o,
  output logic [2:0]  alu_func_o,
  output logic [2:0]  alu_shift_o,
  input  logic [15:0] alu_s_i,
  input  logic [3:0]  alu_cvzn_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_s_o,
  output logic [3:0]  rsp_cvzn_o,
  output logic [3:0]  flags_q_o
);

  localparam logic [2:0] OP_ALU3  = 3'b001;
  localparam logic [2:0] OP_ALU2  = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] F_ADD = 3'd4, F_ADC = 3'd5, F_SUB = 3'd6, F_SBC = 3'd7;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d, s_lo_q, s_lo_d;
  logic [2:0]  op_q, op_d, func_q, func_d, shift_q, shift_d;
  logic        wide_q, wide_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        alu_cin_q, alu_cin_d;
  logic [2:0]  alu_op_q, alu_op_d, alu_func_q, alu_func_d, alu_shift_q, alu_shift_d;
  logic [31:0] rsp_s_q, rsp_s_d;
  logic [3:0]  rsp_cvzn_q, rsp_cvzn_d;
  logic        cin_sel;
  logic        op_legal;
  logic [15:0] lo_s;
  logic [3:0]  lo_f;
  logic [2:0]  hi_func;

`ifdef FLAG_REG_EN
  logic [3:0] flags_q;

  // Persistent flags follow every retired response.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               flags_q <= 4'h0;
    else if (state_q == RESP && rsp_ready_i) flags_q <= rsp_cvzn_q;
  end

  assign flags_q_o = flags_q;
  assign cin_sel   = cmd_use_flag_i ? flags_q[3] : cmd_cin_i;
`else
  logic unused_use_flag;
  assign unused_use_flag = cmd_use_flag_i;
  assign flags_q_o       = 4'h0;
  assign cin_sel         = cmd_cin_i;
`endif

  // Undefined op types never trust the ALU: result 0 with only Z set.
  assign op_legal = (op_q == OP_ALU3) || (op_q == OP_ALU2) || (op_q == OP_SHIFT);
  assign lo_s     = op_legal ? alu_s_i : 16'h0;
  assign lo_f     = op_legal ? alu_cvzn_i : 4'b0010;
  // High pass chains the low carry: plain ADD/SUB become ADC/SBC.
  assign hi_func  = (func_q == F_ADD) ? F_ADC : (func_q == F_SUB) ? F_SBC : func_q;

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_s_o       = rsp_s_q;
  assign rsp_cvzn_o    = rsp_cvzn_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_cin_o     = alu_cin_q;
  assign alu_op_type_o = alu_op_q;
  assign alu_func_o    = alu_func_q;
  assign alu_shift_o   = alu_shift_q;

  // Next state, command capture, ALU drive for the following pass and result assembly.
  always_comb begin
    state_d     = state_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    s_lo_d      = s_lo_q;
    op_d        = op_q;
    func_d      = func_q;
    shift_d     = shift_q;
    wide_d      = wide_q;
    rsp_s_d     = rsp_s_q;
    rsp_cvzn_d  = rsp_cvzn_q;
    alu_a_d     = 16'h0;
    alu_b_d     = 16'h0;
    alu_cin_d   = 1'b0;
    alu_op_d    = 3'h0;
    alu_func_d  = 3'h0;
    alu_shift_d = 3'h0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d     = LO;
        a_hi_d      = cmd_a_i[31:16];
        b_hi_d      = cmd_b_i[31:16];
        op_d        = cmd_op_i;
        func_d      = cmd_func_i;
        shift_d     = cmd_shift_i;
        wide_d      = cmd_wide_i && (cmd_op_i == OP_ALU3);
        alu_a_d     = cmd_a_i[15:0];
        alu_b_d     = cmd_b_i[15:0];
        alu_cin_d   = cin_sel;
        alu_op_d    = cmd_op_i;
        alu_func_d  = cmd_func_i;
        alu_shift_d = cmd_shift_i;
      end
      LO: begin
        s_lo_d = lo_s;
        if (wide_q) begin
          state_d     = HI;
          alu_a_d     = a_hi_q;
          alu_b_d     = b_hi_q;
          alu_cin_d   = alu_cvzn_i[3];
          alu_op_d    = op_q;
          alu_func_d  = hi_func;
          alu_shift_d = shift_q;
        end else begin
          state_d    = RESP;
          rsp_s_d    = {16'h0, lo_s};
          rsp_cvzn_d = lo_f;
        end
      end
      HI: begin
        state_d    = RESP;
        rsp_s_d    = {alu_s_i, s_lo_q};
        rsp_cvzn_d = {alu_cvzn_i[3:2], (s_lo_q == 16'h0) && (alu_s_i == 16'h0), alu_cvzn_i[0]};
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_hi_q      <= 16'h0;
      b_hi_q      <= 16'h0;
      s_lo_q      <= 16'h0;
      op_q        <= 3'h0;
      func_q      <= 3'h0;
      shift_q     <= 3'h0;
      wide_q      <= 1'b0;
      rsp_s_q     <= 32'h0;
      rsp_cvzn_q  <= 4'h0;
      alu_a_q     <= 16'h0;
      alu_b_q     <= 16'h0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= 3'h0;
      alu_func_q  <= 3'h0;
      alu_shift_q <= 3'h0;
    end else begin
      state_q     <= state_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      s_lo_q      <= s_lo_d;
      op_q        <= op_d;
      func_q      <= func_d;
      shift_q     <= shift_d;
      wide_q      <= wide_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cvzn_q  <= rsp_cvzn_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
      alu_func_q  <= alu_func_d;
      alu_shift_q <= alu_shift_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 16-bit ALU answers the DUT's
// ALU port, a 32-bit arithmetic model predicts every response, and directed
// vectors pin latency, chaining controls and reset behaviour.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wide, cmd_cin, cmd_use_flag;
  logic [2:0]  cmd_op, cmd_func, cmd_shift;
  logic [31:0] cmd_a, cmd_b;
  logic [15:0] alu_a, alu_b, alu_s;
  logic        alu_cin;
  logic [2:0]  alu_op_type, alu_func, alu_shift;
  logic [3:0]  alu_cvzn;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_s;
  logic [3:0]  rsp_cvzn, flags_q;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];
  logic [3:0]  mflags = 4'h0;
  logic [31:0] last_s;
  logic [3:0]  last_cvzn;
  logic [15:0] lo_a, hi_a;
  logic [2:0]  lo_func, hi_func;
  logic        lo_cin, hi_cin;
  int          lat;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_func_i(cmd_func), .cmd_shift_i(cmd_shift),
    .cmd_wide_i(cmd_wide), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_cin_i(cmd_cin), .cmd_use_flag_i(cmd_use_flag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_op_type_o(alu_op_type), .alu_func_o(alu_func), .alu_shift_o(alu_shift),
    .alu_s_i(alu_s), .alu_cvzn_i(alu_cvzn),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_s_o(rsp_s), .rsp_cvzn_o(rsp_cvzn), .flags_q_o(flags_q)
  );

  // Behavioural 16-bit ALU. ALU_3: AND/OR/XOR/passB/ADD/ADC/SUB/SBC,
  // ALU_2: NOT A or pass A, shift: SHL/SHR by count+1. Unknown op returns junk.
  function automatic logic [19:0] alu_fn(input logic [2:0] op, func, sh,
                                         input logic [15:0] a, b, input logic cin);
    logic [16:0] r;
    logic [15:0] s, bb;
    logic c, v, ci;
    int n;
    s = 16'h0; c = 1'b0; v = 1'b0; n = int'(sh) + 1;
    case (op)
      3'b001: begin
        if (func[2]) begin
          bb = func[1] ? ~b : b;
          ci = func[0] ? cin : func[1];
          r  = {1'b0, a} + {1'b0, bb} + {16'h0, ci};
          s  = r[15:0];
          c  = r[16];
          v  = (a[15] == bb[15]) && (s[15] != a[15]);
        end else begin
          case (func[1:0])
            2'd0: s = a & b;
            2'd1: s = a | b;
            2'd2: s = a ^ b;
            default: s = b;
          endcase
        end
      end
      3'b010: s = (func == 3'd0) ? ~a : a;
      3'b100: begin
        if (func == 3'd0) begin s = a << n; c = a[16-n]; end
        else              begin s = a >> n; c = a[n-1];  end
      end
      default: return {4'hF, 16'hDEAD};
    endcase
    return {c, v, (s == 16'h0), s[15], s};
  endfunction

  always_comb {alu_cvzn, alu_s} = alu_fn(alu_op_type, alu_func, alu_shift, alu_a, alu_b, alu_cin);

  // Expected {cvzn, s32}: wide ALU_3 ops as one 32-bit operation, narrow ops
  // as a single ALU pass on the low halves, undefined ops as zero result.
  function automatic logic [35:0] exp_fn(input logic [2:0] op, func, sh, input logic wide,
                                         input logic [31:0] a, b, input logic cin);
    logic [32:0] r;
    logic [31:0] s, bb;
    logic c, v, ci;
    logic [19:0] t;
    if (op != 3'b001 && op != 3'b010 && op != 3'b100) return {4'b0010, 32'h0};
    if (wide && op == 3'b001) begin
      c = 1'b0; v = 1'b0;
      if (func[2]) begin
        bb = func[1] ? ~b : b;
        ci = func[0] ? cin : func[1];
        r  = {1'b0, a} + {1'b0, bb} + {32'h0, ci};
        s  = r[31:0];
        c  = r[32];
        v  = (a[31] == bb[31]) && (s[31] != a[31]);
      end else begin
        case (func[1:0])
          2'd0: s = a & b;
          2'd1: s = a | b;
          2'd2: s = a ^ b;
          default: s = b;
        endcase
      end
      return {c, v, (s == 32'h0), s[31], s};
    end
    t = alu_fn(op, func, sh, a[15:0], b[15:0], cin);
    return {t[19:16], 16'h0, t[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Single compare process: response vs model front, flag register, idle ALU drive.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst) begin
      chk("flags_q", flags_q, mflags);
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("spurious_rsp", rsp_valid, 1'b0);
        else begin
          e = exp_q[0];
          chk("rsp_s", rsp_s, e[31:0]);
          chk("rsp_cvzn", rsp_cvzn, e[35:32]);
        end
      end else if (cmd_ready) begin
        chk("idle_alu", {alu_a, alu_b, alu_cin, alu_op_type, alu_func, alu_shift}, 0);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, func, sh, input logic wide,
                        input logic [31:0] a, b, input logic cin, uf,
                        input int hold, input int exp_lat);
    logic [35:0] e;
    logic got;
    logic ce;
    @(negedge clk);
    cmd_op = op; cmd_func = func; cmd_shift = sh; cmd_wide = wide;
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_use_flag = uf; cmd_valid = 1'b1;
`ifdef FLAG_REG_EN
    ce = uf ? mflags[3] : cin;
`else
    ce = cin;
`endif
    e = exp_fn(op, func, sh, wide, a, b, ce);
    exp_q.push_back(e);
    chk("accept_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin lo_a = alu_a; lo_func = alu_func; lo_cin = alu_cin; end
      if (n == 2) begin hi_a = alu_a; hi_func = alu_func; hi_cin = alu_cin; end
      if (rsp_valid) begin got = 1'b1; lat = n; break; end
    end
    chk("latency", lat, exp_lat);
    if (!got) begin
      exp_q.delete();
      return;
    end
    last_s = rsp_s; last_cvzn = rsp_cvzn;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    void'(exp_q.pop_front());
`ifdef FLAG_REG_EN
    mflags = e[35:32];
`endif
    @(negedge clk);
    chk("retire_valid", rsp_valid, 1'b0);
    chk("retire_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'h0; cmd_func = 3'h0; cmd_shift = 3'h0; cmd_wide = 1'b0;
    cmd_a = 32'h0; cmd_b = 32'h0; cmd_cin = 1'b0; cmd_use_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_s, rsp_cvzn, flags_q}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_cin, alu_op_type, alu_func, alu_shift}, 0);
    rst = 1'b0;

    // Narrow ADD overflow into sign bit.
    run_op(3'b001, 3'd4, 3'd0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 0, 2);
    chk("nadd_s", last_s, 32'h0000_8000);
    chk("nadd_cvzn", last_cvzn, 4'b0101);
    chk("nadd_lo_a", lo_a, 16'h7FFF);
    chk("nadd_lo_func", lo_func, 3'd4);

    // Wide ADD with carry across the halves.
    run_op(3'b001, 3'd4, 3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 3);
    chk("wadd_s", last_s, 32'h0001_0000);
    chk("wadd_cvzn", last_cvzn, 4'b0000);
    chk("wadd_hi_func", hi_func, 3'd5);
    chk("wadd_hi_cin", hi_cin, 1'b1);
    chk("wadd_hi_a", hi_a, 16'h0000);

    // Wide ADD wrapping to zero.
    run_op(3'b001, 3'd4, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 3);
    chk("wwrap_s", last_s, 32'h0000_0000);
    chk("wwrap_cvzn", last_cvzn, 4'b1010);

    // Wide SUB borrowing from the high half.
    run_op(3'b001, 3'd6, 3'd0, 1'b1, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 0, 3);
    chk("wsub_s", last_s, 32'h0000_FFFF);
    chk("wsub_cvzn", last_cvzn, 4'b1000);
    chk("wsub_hi_func", hi_func, 3'd7);
    chk("wsub_hi_cin", hi_cin, 1'b0);

    // SHL by one with response held back for three cycles.
    run_op(3'b100, 3'd0, 3'd0, 1'b0, 32'h0000_8001, 32'h0, 1'b0, 1'b0, 3, 2);
    chk("shl_s", last_s, 32'h0000_0002);
    chk("shl_cvzn", last_cvzn, 4'b1000);

    // ALU_2 NOT.
    run_op(3'b010, 3'd0, 3'd0, 1'b0, 32'h0000_00F0, 32'h0, 1'b0, 1'b0, 0, 2);
    chk("not_s", last_s, 32'h0000_FF0F);
    chk("not_cvzn", last_cvzn, 4'b0001);

    // Undefined op type.
    run_op(3'b011, 3'd4, 3'd0, 1'b0, 32'h0000_1234, 32'h0000_1111, 1'b1, 1'b0, 0, 2);
    chk("undef_s", last_s, 32'h0);
    chk("undef_cvzn", last_cvzn, 4'b0010);

    // Wide request on a non-ALU_3 op runs narrow.
    run_op(3'b010, 3'd1, 3'd0, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 2);
    chk("wnar_s", last_s, 32'h0000_5678);
    chk("wnar_hi_func", hi_func, 3'd0);

    // Wide ADC: low pass keeps ADC with the command carry.
    run_op(3'b001, 3'd5, 3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 0, 3);
    chk("wadc_s", last_s, 32'h0001_FFFF);
    chk("wadc_lo_func", lo_func, 3'd5);
    chk("wadc_lo_cin", lo_cin, 1'b1);

    // Model-only patterns: wide XOR, wide SBC with borrow in, SHR by four.
    run_op(3'b001, 3'd2, 3'd0, 1'b1, 32'hA5A5_5A5A, 32'hFFFF_0000, 1'b0, 1'b0, 0, 3);
    run_op(3'b001, 3'd7, 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 3);
    chk("wsbc_s", last_s, 32'hFFFF_FFFF);
    run_op(3'b100, 3'd1, 3'd3, 1'b0, 32'h0000_00F8, 32'h0, 1'b0, 1'b0, 0, 2);
    chk("shr_s", last_s, 32'h0000_000F);

    // Carry flag feeding a later ADC.
    run_op(3'b001, 3'd4, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 3);
    run_op(3'b001, 3'd5, 3'd0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 0, 2);
`ifdef FLAG_REG_EN
    chk("flag_adc_s", last_s, 32'h0000_0003);
`else
    chk("noflag_adc_s", last_s, 32'h0000_0002);
`endif

    // Reset while the high pass is on the ALU.
    @(negedge clk);
    cmd_op = 3'b001; cmd_func = 3'd4; cmd_wide = 1'b1; cmd_use_flag = 1'b0;
    cmd_a = 32'h1111_2222; cmd_b = 32'h3333_4444; cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rsthi_func", alu_func, 3'd5);
    chk("rsthi_a", alu_a, 16'h1111);
    rst = 1'b1; mflags = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rsthi_valid", rsp_valid, 1'b0);
    chk("rsthi_ready", cmd_ready, 1'b1);
    chk("rsthi_alu", {alu_a, alu_b, alu_cin, alu_op_type, alu_func, alu_shift}, 0);
    chk("rsthi_rsp", {rsp_s, rsp_cvzn, flags_q}, 0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rsthi_no_rsp", rsp_valid, 1'b0);
    end

    // Still working after the mid-flight reset.
    run_op(3'b001, 3'd0, 3'd0, 1'b0, 32'h0000_F0F0, 32'h0000_3C3C, 1'b0, 1'b0, 0, 2);
    chk("post_and_s", last_s, 32'h0000_3030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
